// File: rtl/mem_bus_pkg.sv
// Shared encodings for the ROM/RAM bus controller: FSM states, memory regions,
// bus owners and the default RAM base address.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [12:0] RAM_BASE = 13'h1800;

    localparam logic REG_ROM = 1'b0;
    localparam logic REG_RAM = 1'b1;

    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Wait-state count for a region, given both region settings.
    function automatic logic [2:0] region_wait(input logic region,
                                               input logic [2:0] rom_wait,
                                               input logic [2:0] ram_wait);
        return (region == REG_RAM) ? ram_wait : rom_wait;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Requester ports C and D plus the memory-side bus of the controller.
// slave = the controller; master = requesters and memory macros.
interface mem_bus_ctrl_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) ();
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ack;
    logic              c_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              rom_sel;
    logic              ram_sel;
    logic              mem_rd;
    logic              mem_wr;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_ack, c_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack, d_err,
        output mem_addr, mem_wdata, rom_sel, ram_sel, mem_rd, mem_wr,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_ack, c_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack, d_err,
        input  mem_addr, mem_wdata, rom_sel, ram_sel, mem_rd, mem_wr,
        output mem_rdata
    );
endinterface

// File: rtl/mem_wait_timer.sv
// 3-bit wait-state down-counter: load a start value, decrement on request,
// flag when it has reached zero.
module mem_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic [2:0] value,
    output logic       zero
);
    logic [2:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= 3'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec) begin
            count_reg <= count_reg - 3'd1;
        end
    end

    assign value = count_reg;
    assign zero  = (count_reg == 3'd0);
endmodule

// File: rtl/mem_bus_ctrl.sv
// Two-port ROM/RAM bus controller: C/D arbitration with a fairness streak,
// region decode, per-region wait states and rejection of writes to ROM.
module mem_bus_ctrl #(
    parameter int                ADDR_W    = 13,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] RAM_BASE  = mem_bus_pkg::RAM_BASE,
    parameter int                ROM_WAIT  = 1,
    parameter int                RAM_WAIT  = 0,
    parameter int                MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_bus_ctrl_if.slave  bus
);
    import mem_bus_pkg::*;

    localparam logic [3:0] BURST_MAX  = 4'(MAX_BURST);
    localparam logic [2:0] ROM_WAIT_V = 3'(ROM_WAIT);
    localparam logic [2:0] RAM_WAIT_V = 3'(RAM_WAIT);

    state_t            state_reg, state_next;
    logic              owner_reg, we_reg, region_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] c_rdata_reg, d_rdata_reg;
    logic              c_err_reg, d_err_reg;
    logic [3:0]        streak_reg;

    logic              any_req, grant_d, grant;
    logic              sel_we, sel_region, rom_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        wait_load, wait_value;
    logic              wait_zero, wait_dec;

    // D only overtakes a pending C request once C has used up its burst.
    always_comb begin
        any_req    = bus.c_req | bus.d_req;
        grant_d    = bus.d_req && (!bus.c_req || (streak_reg == BURST_MAX));
        grant      = (state_reg == IDLE) && any_req;
        sel_we     = grant_d ? bus.d_we    : bus.c_we;
        sel_addr   = grant_d ? bus.d_addr  : bus.c_addr;
        sel_wdata  = grant_d ? bus.d_wdata : bus.c_wdata;
        sel_region = (sel_addr >= RAM_BASE) ? REG_RAM : REG_ROM;
        rom_write  = sel_we && (sel_region == REG_ROM);
        wait_load  = region_wait(sel_region, ROM_WAIT_V, RAM_WAIT_V);
        wait_dec   = (state_reg == ACCESS) && (wait_value != 3'd0);
    end

    mem_wait_timer u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (grant),
        .load_val (wait_load),
        .dec      (wait_dec),
        .value    (wait_value),
        .zero     (wait_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = rom_write ? DONE : ACCESS;
            ACCESS:  if (wait_zero) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg   <= OWN_C;
            we_reg      <= 1'b0;
            region_reg  <= REG_ROM;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            c_rdata_reg <= '0;
            d_rdata_reg <= '0;
            c_err_reg   <= 1'b0;
            d_err_reg   <= 1'b0;
            streak_reg  <= 4'd0;
        end else begin
            if (grant) begin
                owner_reg  <= grant_d ? OWN_D : OWN_C;
                we_reg     <= sel_we;
                region_reg <= sel_region;
                addr_reg   <= sel_addr;
                wdata_reg  <= sel_wdata;
                if (grant_d) begin
                    d_err_reg <= rom_write;
                end else begin
                    c_err_reg <= rom_write;
                end
            end
            // Streak counts C grants taken while D was waiting.
            if (state_reg == IDLE) begin
                if (!bus.d_req || grant_d) begin
                    streak_reg <= 4'd0;
                end else if (bus.c_req && (streak_reg != BURST_MAX)) begin
                    streak_reg <= streak_reg + 4'd1;
                end
            end
            if ((state_reg == ACCESS) && wait_zero && !we_reg) begin
                if (owner_reg == OWN_D) begin
                    d_rdata_reg <= bus.mem_rdata;
                end else begin
                    c_rdata_reg <= bus.mem_rdata;
                end
            end
        end
    end

    // Selects and strobes are decoded from the registered state so they vanish with reset.
    always_comb begin
        bus.rom_sel   = (state_reg == ACCESS) && (region_reg == REG_ROM);
        bus.ram_sel   = (state_reg == ACCESS) && (region_reg == REG_RAM);
        bus.mem_rd    = (state_reg == ACCESS) && !we_reg;
        bus.mem_wr    = (state_reg == ACCESS) && we_reg;
        bus.mem_addr  = addr_reg;
        bus.mem_wdata = wdata_reg;
        bus.c_ack     = (state_reg == DONE) && (owner_reg == OWN_C);
        bus.d_ack     = (state_reg == DONE) && (owner_reg == OWN_D);
        bus.c_err     = c_err_reg;
        bus.d_err     = d_err_reg;
        bus.c_rdata   = c_rdata_reg;
        bus.d_rdata   = d_rdata_reg;
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed requests push expected acks,
// a negedge monitor pops and compares each ack with the bus activity it saw.
module tb_mem_bus_ctrl;

    typedef struct {
        bit          port;     // 0 = C, 1 = D
        bit          we;
        logic [7:0]  rdata;
        bit          err;
        int          rom_cyc;
        int          ram_cyc;
        logic [12:0] addr;
        logic [7:0]  wdata;
        int          lat;      // absolute ack cycle, -1 = not checked
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_fail;
    int   ack_total;
    exp_t sb[$];

    logic [7:0]  ram_model [0:2047];
    int          n_rom, n_ram, n_rd, n_wr;
    logic [12:0] seen_addr;
    logic [7:0]  seen_wdata;
    logic [7:0]  exp_c_last, exp_d_last;

    mem_bus_ctrl_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    mem_bus_ctrl #(
        .ADDR_W(13), .DATA_W(8), .RAM_BASE(13'h1800),
        .ROM_WAIT(1), .RAM_WAIT(0), .MAX_BURST(4)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: ROM returns addr ^ A5, RAM is initialised to index ^ 3C.
    initial begin
        for (int i = 0; i < 2048; i++) ram_model[i] = 8'(i) ^ 8'h3C;
    end
    always @(posedge clk) begin
        if (bus.mem_wr && bus.ram_sel) ram_model[bus.mem_addr[10:0]] <= bus.mem_wdata;
    end
    always_comb begin
        bus.mem_rdata = 8'h00;
        if (bus.rom_sel)      bus.mem_rdata = bus.mem_addr[7:0] ^ 8'hA5;
        else if (bus.ram_sel) bus.mem_rdata = ram_model[bus.mem_addr[10:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 32'({bus.c_ack, bus.c_err, bus.d_ack, bus.d_err,
                                   bus.rom_sel, bus.ram_sel, bus.mem_rd, bus.mem_wr}), 32'd0);
        check({tag, "_rdata"}, 32'({bus.c_rdata, bus.d_rdata}), 32'd0);
        check({tag, "_bus"}, 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
    endtask

    // Monitor: counts bus activity per transaction, compares on every ack.
    always @(negedge clk) begin
        exp_t  e;
        logic [7:0] exp_rd;
        if (!rst_n) begin
            n_rom = 0; n_ram = 0; n_rd = 0; n_wr = 0;
            exp_c_last = 8'h00; exp_d_last = 8'h00;
        end else begin
            if (bus.rom_sel) n_rom++;
            if (bus.ram_sel) n_ram++;
            if (bus.mem_rd)  n_rd++;
            if (bus.mem_wr)  n_wr++;
            if (bus.rom_sel || bus.ram_sel) begin
                seen_addr  = bus.mem_addr;
                seen_wdata = bus.mem_wdata;
            end
            if (bus.c_ack || bus.d_ack) begin
                ack_total++;
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'({bus.c_ack, bus.d_ack}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", 32'(bus.d_ack), 32'(e.port));
                    check("ack_both", 32'(bus.c_ack & bus.d_ack), 32'd0);
                    if (e.port == 1'b0) begin
                        exp_rd = e.we ? exp_c_last : e.rdata;
                        check("c_err", 32'(bus.c_err), 32'(e.err));
                        check("c_rdata", 32'(bus.c_rdata), 32'(exp_rd));
                        check("d_rdata_held", 32'(bus.d_rdata), 32'(exp_d_last));
                        exp_c_last = exp_rd;
                    end else begin
                        exp_rd = e.we ? exp_d_last : e.rdata;
                        check("d_err", 32'(bus.d_err), 32'(e.err));
                        check("d_rdata", 32'(bus.d_rdata), 32'(exp_rd));
                        check("c_rdata_held", 32'(bus.c_rdata), 32'(exp_c_last));
                        exp_d_last = exp_rd;
                    end
                    check("rom_sel_cycles", 32'(n_rom), 32'(e.rom_cyc));
                    check("ram_sel_cycles", 32'(n_ram), 32'(e.ram_cyc));
                    check("mem_rd_cycles", 32'(n_rd), e.we ? 32'd0 : 32'(e.rom_cyc + e.ram_cyc));
                    check("mem_wr_cycles", 32'(n_wr), e.we ? 32'(e.rom_cyc + e.ram_cyc) : 32'd0);
                    if (e.rom_cyc + e.ram_cyc > 0) check("mem_addr", 32'(seen_addr), 32'(e.addr));
                    if (e.we && (e.ram_cyc > 0)) check("mem_wdata", 32'(seen_wdata), 32'(e.wdata));
                    if (e.lat >= 0) check("ack_latency", 32'(cyc), 32'(e.lat));
                end
                n_rom = 0; n_ram = 0; n_rd = 0; n_wr = 0;
            end
        end
    end

    function automatic exp_t mk(input bit port, input bit we, input logic [12:0] addr,
                                input logic [7:0] wdata, input logic [7:0] rdata, input bit err,
                                input int rom_cyc, input int ram_cyc, input int lat);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        e.err = err; e.rom_cyc = rom_cyc; e.ram_cyc = ram_cyc; e.lat = lat;
        return e;
    endfunction

    task automatic wait_acks(input int target, input string tag);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (ack_total >= target) return;
        end
        check({tag, "_ack_timeout"}, 32'(ack_total), 32'(target));
    endtask

    // One request on one port; lat is the expected IDLE-to-ack distance.
    task automatic issue(input bit port, input bit we, input logic [12:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata, input bit err,
                         input int rom_cyc, input int ram_cyc, input int lat);
        int base;
        @(posedge clk); #1;
        base = ack_total;
        sb.push_back(mk(port, we, addr, wdata, rdata, err, rom_cyc, ram_cyc, cyc + lat));
        if (port == 1'b0) begin
            bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_req = 1'b1;
        end else begin
            bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
        end
        wait_acks(base + 1, "issue");
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    initial begin
        int base;
        n_vec = 0; n_fail = 0; ack_total = 0;
        rst_n = 1'b0;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Single transactions: ROM read, RAM write, rejected ROM write, err clear, boundaries.
        issue(0, 0, 13'h0005, 8'h00, 8'hA0, 0, 2, 0, 3);
        issue(0, 1, 13'h1A00, 8'h5A, 8'h00, 0, 0, 1, 2);
        issue(1, 1, 13'h0100, 8'h33, 8'h00, 1, 0, 0, 1);
        issue(1, 0, 13'h1A00, 8'h00, 8'h5A, 0, 0, 1, 2);
        issue(0, 0, 13'h17FF, 8'h00, 8'h5A, 0, 2, 0, 3);
        issue(0, 0, 13'h1800, 8'h00, 8'h3C, 0, 0, 1, 2);
        issue(1, 0, 13'h1FFF, 8'h00, 8'hC3, 0, 0, 1, 2);

        // Both requesters held high: C,C,C,C,D,C,C,C,C,D.
        @(posedge clk); #1;
        base = ack_total;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) sb.push_back(mk(0, 0, 13'h0010, 8'h00, 8'hB5, 0, 2, 0, -1));
            sb.push_back(mk(1, 0, 13'h1810, 8'h00, 8'h2C, 0, 0, 1, -1));
        end
        bus.c_we = 1'b0; bus.c_addr = 13'h0010; bus.c_req = 1'b1;
        bus.d_we = 1'b0; bus.d_addr = 13'h1810; bus.d_req = 1'b1;
        wait_acks(base + 10, "burst");
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;

        // Reset in the second ACCESS cycle of a ROM read aborts it without an ack.
        @(posedge clk); #1;
        bus.c_we = 1'b0; bus.c_addr = 13'h0020; bus.c_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        @(posedge clk); #1 bus.c_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        issue(0, 0, 13'h0021, 8'h00, 8'h84, 0, 2, 0, 3);
        issue(0, 1, 13'h1FFF, 8'h77, 8'h00, 0, 0, 1, 2);
        issue(1, 0, 13'h1FFF, 8'h00, 8'h77, 0, 0, 1, 2);
        issue(0, 1, 13'h0000, 8'h11, 8'h00, 1, 0, 0, 1);
        issue(0, 0, 13'h1FFF, 8'h00, 8'h77, 0, 0, 1, 2);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
